// File: rtl/seg_display_pkg.sv
// Shared glyph constants, FSM state type and BCD sizing helper for seg_display_ctrl.
package seg_display_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h98;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_OVF   = 8'hB6;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // ceil(w * log10(2)) in integer arithmetic: decimal digits needed for a w-bit value.
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/seg_glyph.sv
// Combinational 4-bit digit to active-low seven-segment glyph encoder (DP off).
module seg_glyph
  import seg_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (digit)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Handshaked hex/decimal, signed/unsigned value to seven-segment display controller.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int W      = 10,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  logic                  in_signed,
  input  logic                  in_dec,
  output logic [DIGITS*8-1:0]   seg,
  output logic                  overflow,
  output logic                  done
);

  localparam int BCD_N = bcd_digits(W);
  localparam int ND    = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int DW    = 4 * ND;
  localparam int CW    = $clog2(W + 1);

  state_t                state_q, state_d;
  logic [W-1:0]          bin_q, bin_d;
  logic                  dec_q, dec_d;
  logic                  sign_q, sign_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIGITS*8-1:0]   seg_q, seg_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [W-1:0]          mag;
  logic [DW-1:0]         bcd_adj;
  logic [7:0]            n_sig;
  logic [7:0]            cap;
  logic                  ovf_w;
  logic [DIGITS*8-1:0]   seg_next;
  logic [7:0]            glyph_w [DIGITS];

  assign mag = sign_q ? (~bin_q + 1'b1) : bin_q;

  // Digits above n_sig-1 are zero; this includes BCD positions that have no display.
  always_comb begin
    n_sig = 8'd1;
    for (int i = 0; i < ND; i++) begin
      if (dig_q[4*i +: 4] != 4'd0) n_sig = 8'(i + 1);
    end
  end

  assign cap   = 8'(DIGITS) - {7'd0, sign_q};
  assign ovf_w = (n_sig > cap);

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      seg_glyph u_glyph (
        .digit (dig_q[4*gi +: 4]),
        .glyph (glyph_w[gi])
      );
`ifdef SEG_LZB_EN
      assign seg_next[8*gi +: 8] = ovf_w                          ? SEG_OVF   :
                                   (8'(gi) < n_sig)               ? glyph_w[gi] :
                                   (sign_q && (8'(gi) == n_sig))  ? SEG_MINUS : SEG_BLANK;
`else
      assign seg_next[8*gi +: 8] = ovf_w                          ? SEG_OVF   :
                                   (sign_q && (gi == DIGITS - 1)) ? SEG_MINUS : glyph_w[gi];
`endif
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    dec_d    = dec_q;
    sign_d   = sign_q;
    dig_d    = dig_q;
    cnt_d    = cnt_q;
    seg_d    = seg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    bcd_adj  = dig_q;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = in_data;
          sign_d  = in_signed & in_data[W-1];
          dec_d   = in_dec;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (dec_q) begin
          dig_d   = '0;
          bin_d   = mag;
          cnt_d   = CW'(W);
          state_d = SHIFT;
        end else begin
          dig_d   = DW'(mag);
          state_d = DONE;
        end
      end
      SHIFT: begin
        for (int i = 0; i < ND; i++) begin
          if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
        end
        {dig_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        seg_d   = seg_next;
        ovf_d   = ovf_w;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      dec_q   <= 1'b0;
      sign_q  <= 1'b0;
      dig_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= {DIGITS{SEG_BLANK}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      dec_q   <= dec_d;
      sign_q  <= sign_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign seg      = seg_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: a W=10/DIGITS=6 instance and a W=10/DIGITS=2 instance.
module tb_seg_display_ctrl;

`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v6, v2;
  logic [9:0]  data;
  logic        sgn, dec;
  logic        r6, r2;
  logic [47:0] seg6;
  logic [15:0] seg2;
  logic        ovf6, ovf2, done6, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_display_ctrl #(.W(10), .DIGITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .in_data(data),
    .in_signed(sgn), .in_dec(dec), .seg(seg6), .overflow(ovf6), .done(done6)
  );

  seg_display_ctrl #(.W(10), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_data(data),
    .in_signed(sgn), .in_dec(dec), .seg(seg2), .overflow(ovf2), .done(done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic wait_done(input bit use2, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(use2 ? done2 : done6) && lat < 100);
  endtask

  task automatic xfer(input string tag, input bit use2, input logic [9:0] d, input bit s,
                      input bit dc, input logic [47:0] exp_seg, input bit exp_ovf, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_rdy_in"}, use2 ? r2 : r6, 1);
    data = d; sgn = s; dec = dc;
    if (use2) v2 = 1'b1; else v6 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; v6 = 1'b0;
    wait_done(use2, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_seg"}, use2 ? {32'h0, seg2} : seg6, exp_seg);
    check({tag, "_ovf"}, use2 ? ovf2 : ovf6, exp_ovf);
    check({tag, "_rdy_out"}, use2 ? r2 : r6, 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, use2 ? done2 : done6, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; v6 = 1'b0; v2 = 1'b0; data = '0; sgn = 1'b0; dec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg6", seg6, 48'hFFFF_FFFF_FFFF);
    check("rst_seg2", {32'h0, seg2}, 64'hFFFF);
    check("rst_ovf", ovf6, 0);
    check("rst_done", done6, 0);
    check("rst_rdy", r6, 1);
    @(negedge clk); rst_n = 1'b1;

    xfer("dec999", 0, 10'd999, 0, 1, LZB ? 48'hFFFFFF989898 : 48'hC0C0C0989898, 0, 12);

    // Abort a decimal conversion with reset while in SHIFT.
    @(negedge clk);
    data = 10'd512; sgn = 1'b0; dec = 1'b1; v6 = 1'b1;
    @(posedge clk); #1; v6 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("abort_seg", seg6, 48'hFFFF_FFFF_FFFF);
    check("abort_ovf", ovf6, 0);
    check("abort_done", done6, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("abort_rdy", r6, 1);
    repeat (14) @(posedge clk);
    #1;
    check("abort_no_update", seg6, 48'hFFFF_FFFF_FFFF);

    xfer("dec512_after", 0, 10'd512, 0, 1, LZB ? 48'hFFFFFF92F9A4 : 48'hC0C0C092F9A4, 0, 12);
    xfer("decm512", 0, 10'h200, 1, 1, LZB ? 48'hFFFFBF92F9A4 : 48'hBFC0C092F9A4, 0, 12);
    xfer("dec1023", 0, 10'h3FF, 0, 1, LZB ? 48'hFFFFF9C0A4B0 : 48'hC0C0F9C0A4B0, 0, 12);
    xfer("dec0", 0, 10'd0, 0, 1, LZB ? 48'hFFFFFFFFFFC0 : 48'hC0C0C0C0C0C0, 0, 12);
    xfer("hex3ff", 0, 10'h3FF, 0, 0, LZB ? 48'hFFFFFFB08E8E : 48'hC0C0C0B08E8E, 0, 2);
    xfer("hexm1", 0, 10'h3FF, 1, 0, LZB ? 48'hFFFFFFFFBFF9 : 48'hBFC0C0C0C0F9, 0, 2);
    xfer("hexm512", 0, 10'h200, 1, 0, LZB ? 48'hFFFFBFA4C0C0 : 48'hBFC0C0A4C0C0, 0, 2);
    xfer("d2_100", 1, 10'd100, 0, 1, 48'hB6B6, 1, 12);
    xfer("d2_99", 1, 10'd99, 0, 1, 48'h9898, 0, 12);
    xfer("d2_m1", 1, 10'h3FF, 1, 1, 48'hBFF9, 0, 12);
    xfer("d2_m10", 1, 10'h3F6, 1, 1, 48'hB6B6, 1, 12);

    // in_valid held high while busy with in_data changing every cycle.
    @(negedge clk);
    data = 10'd123; sgn = 1'b0; dec = 1'b1; v6 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin
      data = 10'(lat * 97 + 500);
      check("hold_busy_rdy", r6, 0);
      @(posedge clk); #1;
      lat++;
    end while (!done6 && lat < 100);
    check("hold_lat", lat, 12);
    check("hold_seg", seg6, LZB ? 48'hFFFFFFF9A4B0 : 48'hC0C0C0F9A4B0);
    check("hold_rdy", r6, 1);
    data = 10'd45;
    @(posedge clk); #1;
    v6 = 1'b0;
    check("hold_recapture", r6, 0);
    wait_done(0, lat);
    check("hold2_lat", lat, 12);
    check("hold2_seg", seg6, LZB ? 48'hFFFFFFFF9992 : 48'hC0C0C0C09992);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
